// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types for the full-speed UTM (transmit and receive sides).
//   bus8_t            : one byte on the UTMI data bus
//   utmi_op_mode_t    : UTMI OpMode encoding
//   utmi_line_state_t : synchronized {D-, D+} line state
package usb_utmi_pkg;

  typedef logic [7:0] bus8_t;

  typedef enum logic [1:0] {
    OP_NORMAL      = 2'b00,
    OP_NON_DRIVING = 2'b01,
    OP_DISABLE_BS  = 2'b10,
    OP_RESERVED    = 2'b11
  } utmi_op_mode_t;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } utmi_line_state_t;

endpackage

// File: rtl/usb_utm_rx_dpll.sv
// Receive front end: metastability chain on the raw D+/D- receivers, edge
// detection on synchronized D+ and a 2-bit phase counter that recovers the
// full-speed bit clock from the 4x sampling clock.
// Ports:
//   clk, rst     : 48 MHz clock, synchronous active-high reset
//   dp_rx, dm_rx : raw asynchronous single-ended receiver outputs
//   line_state   : synchronized {dm, dp}, SYNC_STAGES cycles of latency
//   bit_stb      : one-cycle strobe near the centre of each received bit
module usb_utm_rx_dpll
  import usb_utmi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dp_rx,
  input  logic             dm_rx,
  output utmi_line_state_t line_state,
  output logic             bit_stb
);

  logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d;
  logic [SYNC_STAGES-1:0] dm_sync_q, dm_sync_d;
  logic [1:0]             phase_q, phase_d;
  logic                   dp_change;

  always_comb begin
    dp_sync_d = {dp_sync_q[SYNC_STAGES-2:0], dp_rx};
    dm_sync_d = {dm_sync_q[SYNC_STAGES-2:0], dm_rx};
    // Look one stage ahead so the counter reads 0 on the very first cycle
    // line_state shows the new level; the strobe then lands two cycles in.
    dp_change = dp_sync_q[SYNC_STAGES-1] ^ dp_sync_q[SYNC_STAGES-2];
    phase_d   = dp_change ? 2'd0 : phase_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync_q <= '0;
      dm_sync_q <= '0;
      phase_q   <= 2'd0;
    end else begin
      dp_sync_q <= dp_sync_d;
      dm_sync_q <= dm_sync_d;
      phase_q   <= phase_d;
    end
  end

  assign line_state = utmi_line_state_t'({dm_sync_q[SYNC_STAGES-1], dp_sync_q[SYNC_STAGES-1]});
  assign bit_stb    = (phase_q == 2'd2);

endmodule

// File: rtl/usb_utm_rx.sv
// Full-speed UTM receiver: NRZI decode, SYNC detection, bit unstuffing,
// EOP detection and byte assembly behind the UTMI receive interface.
// Ports:
//   clk, rst           : 48 MHz clock, synchronous active-high reset
//   suspend_m          : 0 = suspended, receiver held idle
//   op_mode            : UTMI OpMode; receive only in NORMAL / NON_DRIVING
//   dp_rx, dm_rx       : raw asynchronous single-ended receivers
//   line_state         : synchronized {dm, dp}
//   data_out, rx_valid : received byte and its one-cycle strobe
//   rx_active          : packet in progress (SYNC seen, EOP not finished)
//   rx_error           : one-cycle receive error strobe
module usb_utm_rx
  import usb_utmi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SYNC_MIN_ZEROS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             suspend_m,
  input  utmi_op_mode_t    op_mode,
  input  logic             dp_rx,
  input  logic             dm_rx,
  output utmi_line_state_t line_state,
  output bus8_t            data_out,
  output logic             rx_valid,
  output logic             rx_active,
  output logic             rx_error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERROR
  } rx_state_t;

  localparam logic [2:0] MIN_ZEROS = 3'(SYNC_MIN_ZEROS);

  utmi_line_state_t ls;
  logic             bit_stb;
  rx_state_t        state_q, state_d;
  logic             prev_k_q, prev_k_d;
  logic [2:0]       zero_cnt_q, zero_cnt_d;
  logic [2:0]       ones_cnt_q, ones_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  bus8_t            shift_q, shift_d;
  bus8_t            data_out_q, data_out_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_active_q, rx_active_d;
  logic             rx_error_q, rx_error_d;
  logic             err_se0_q, err_se0_d;
  logic             rx_en, is_jk, is_k, nrzi_bit;

  usb_utm_rx_dpll #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dpll (
    .clk       (clk),
    .rst       (rst),
    .dp_rx     (dp_rx),
    .dm_rx     (dm_rx),
    .line_state(ls),
    .bit_stb   (bit_stb)
  );

  assign rx_en    = suspend_m && (op_mode == OP_NORMAL || op_mode == OP_NON_DRIVING);
  assign is_k     = (ls == LS_K);
  assign is_jk    = (ls == LS_J) || is_k;
  // NRZI: no transition between bit centres decodes as 1.
  assign nrzi_bit = (is_k == prev_k_q);

  always_comb begin
    state_d     = state_q;
    prev_k_d    = prev_k_q;
    zero_cnt_d  = zero_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_out_d  = data_out_q;
    rx_active_d = rx_active_q;
    err_se0_d   = err_se0_q;
    rx_valid_d  = 1'b0;
    rx_error_d  = 1'b0;

    if (!rx_en) begin
      state_d     = ST_IDLE;
      rx_active_d = 1'b0;
      prev_k_d    = 1'b0;
    end else if (bit_stb) begin
      if (is_jk) prev_k_d = is_k;
      unique case (state_q)
        ST_IDLE: begin
          // Idle is J, so the first K is already the first SYNC zero.
          prev_k_d = is_k;
          if (is_k) begin
            state_d    = ST_SYNC;
            zero_cnt_d = 3'd1;
          end
        end
        ST_SYNC: begin
          if (!is_jk) begin
            state_d = ST_IDLE;
          end else if (!nrzi_bit) begin
            if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
          end else if (zero_cnt_q >= MIN_ZEROS) begin
            state_d     = ST_DATA;
            rx_active_d = 1'b1;
            ones_cnt_d  = 3'd0;
            bit_cnt_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (ls == LS_SE0) begin
            state_d = ST_EOP;
            if (bit_cnt_q != 3'd0) rx_error_d = 1'b1;
          end else if (ls == LS_SE1) begin
            state_d    = ST_ERROR;
            rx_error_d = 1'b1;
            err_se0_d  = 1'b0;
          end else if (ones_cnt_q == 3'd6) begin
            // Stuff slot: a 0 is discarded, a 1 is a stuffing violation.
            if (nrzi_bit) begin
              state_d    = ST_ERROR;
              rx_error_d = 1'b1;
              err_se0_d  = 1'b0;
            end else begin
              ones_cnt_d = 3'd0;
            end
          end else begin
            shift_d    = {nrzi_bit, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
            if (bit_cnt_q == 3'd7) begin
              data_out_d = {nrzi_bit, shift_q[7:1]};
              rx_valid_d = 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (ls == LS_J) begin
            state_d     = ST_IDLE;
            rx_active_d = 1'b0;
          end else if (ls != LS_SE0) begin
            state_d    = ST_ERROR;
            rx_error_d = 1'b1;
            err_se0_d  = 1'b0;
          end
        end
        ST_ERROR: begin
          // Leave only on an SE0 directly followed by J.
          if (ls == LS_SE0) begin
            err_se0_d = 1'b1;
          end else if (ls == LS_J) begin
            if (err_se0_q) begin
              state_d     = ST_IDLE;
              rx_active_d = 1'b0;
            end
          end else begin
            err_se0_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prev_k_q    <= 1'b0;
      zero_cnt_q  <= 3'd0;
      ones_cnt_q  <= 3'd0;
      bit_cnt_q   <= 3'd0;
      data_out_q  <= '0;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_error_q  <= 1'b0;
      err_se0_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_k_q    <= prev_k_d;
      zero_cnt_q  <= zero_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_out_q  <= data_out_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_error_q  <= rx_error_d;
      err_se0_q   <= err_se0_d;
    end
  end

  // Partial-byte shifter: contents are meaningless until bit_cnt wraps.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign line_state = ls;
  assign data_out   = data_out_q;
  assign rx_valid   = rx_valid_q;
  assign rx_active  = rx_active_q;
  assign rx_error   = rx_error_q;

endmodule

// File: tb/tb_usb_utm_rx.sv
// Directed bench for usb_utm_rx: drives NRZI line states bit by bit and
// checks received bytes, strobes and rx_active against hand-derived values.
module tb_usb_utm_rx;
  import usb_utmi_pkg::*;

  logic             clk;
  logic             rst;
  logic             suspend_m;
  utmi_op_mode_t    op_mode;
  logic             dp_rx;
  logic             dm_rx;
  utmi_line_state_t line_state;
  bus8_t            data_out;
  logic             rx_valid;
  logic             rx_active;
  logic             rx_error;

  usb_utm_rx #(
    .SYNC_STAGES   (2),
    .SYNC_MIN_ZEROS(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .suspend_m (suspend_m),
    .op_mode   (op_mode),
    .dp_rx     (dp_rx),
    .dm_rx     (dm_rx),
    .line_state(line_state),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Bus monitor: records every delivered byte and counts strobes/edges.
  logic [7:0] rx_bytes[$];
  int         err_cnt  = 0;
  int         rise_cnt = 0;
  int         viol_cnt = 0;
  logic       act_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) rx_bytes.push_back(data_out);
    if (rx_error) err_cnt++;
    if (rx_active && !act_prev) rise_cnt++;
    if (rx_valid && !rx_active) viol_cnt++;
    act_prev = rx_active;
  end

  int   checks = 0;
  int   errors = 0;
  logic cur_k  = 1'b0;
  int   ones   = 0;
  logic stuff_en  = 1'b1;
  logic drift     = 1'b0;
  logic drift_tgl = 1'b0;
  int   b0, e0, a0;

  logic [7:0] drift_bytes [16] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3,
                                   8'h7E, 8'h81, 8'h12, 8'h34, 8'hFE, 8'h01, 8'h80, 8'h7F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    if (i < rx_bytes.size()) return rx_bytes[i];
    return 8'hxx;
  endfunction

  task automatic send_ls(input logic [1:0] ls, input int n);
    {dm_rx, dp_rx} = ls;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic next_per(output int n);
    if (drift) begin
      n = drift_tgl ? 5 : 3;
      drift_tgl = ~drift_tgl;
    end else begin
      n = 4;
    end
  endtask

  task automatic nrzi_bit(input logic b);
    int n;
    if (!b) cur_k = ~cur_k;
    next_per(n);
    send_ls(cur_k ? 2'b10 : 2'b01, n);
  endtask

  task automatic data_bit(input logic b);
    nrzi_bit(b);
    if (b) ones++;
    else ones = 0;
    if (stuff_en && ones == 6) begin
      nrzi_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) data_bit(v[i]);
  endtask

  task automatic send_sync();
    cur_k = 1'b0;
    for (int i = 0; i < 7; i++) nrzi_bit(1'b0);
    nrzi_bit(1'b1);
    ones = 0;
  endtask

  task automatic send_eop();
    int n;
    next_per(n);
    send_ls(2'b00, n);
    next_per(n);
    send_ls(2'b00, n);
    cur_k = 1'b0;
    next_per(n);
    send_ls(2'b01, n);
    send_ls(2'b01, 24);
  endtask

  task automatic mark();
    b0 = rx_bytes.size();
    e0 = err_cnt;
    a0 = rise_cnt;
  endtask

  initial begin
    rst       = 1'b1;
    suspend_m = 1'b1;
    op_mode   = OP_NORMAL;
    {dm_rx, dp_rx} = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line_state", 32'(line_state), 32'(LS_SE0));
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_active", 32'(rx_active), 32'h0);
    check("rst_rx_error", 32'(rx_error), 32'h0);
    rst = 1'b0;
    send_ls(2'b01, 40);
    check("idle_line_state", 32'(line_state), 32'(LS_J));

    // Clean packet C3 A5
    mark();
    cur_k = 1'b0;
    for (int i = 0; i < 7; i++) nrzi_bit(1'b0);
    check("clean_active_before_sync_end", 32'(rx_active), 32'h0);
    nrzi_bit(1'b1);
    ones = 0;
    send_byte(8'hC3);
    check("clean_active_in_packet", 32'(rx_active), 32'h1);
    send_byte(8'hA5);
    send_eop();
    check("clean_count", 32'(rx_bytes.size() - b0), 32'd2);
    check("clean_byte0", 32'(byte_at(b0)), 32'hC3);
    check("clean_byte1", 32'(byte_at(b0 + 1)), 32'hA5);
    check("clean_errors", 32'(err_cnt - e0), 32'd0);
    check("clean_rises", 32'(rise_cnt - a0), 32'd1);
    check("clean_active_after", 32'(rx_active), 32'h0);

    // Stuffing FF 00
    mark();
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_eop();
    check("stuff_count", 32'(rx_bytes.size() - b0), 32'd2);
    check("stuff_byte0", 32'(byte_at(b0)), 32'hFF);
    check("stuff_byte1", 32'(byte_at(b0 + 1)), 32'h00);
    check("stuff_errors", 32'(err_cnt - e0), 32'd0);

    // Stuff violation right after a completed byte ending in six 1s
    mark();
    send_sync();
    stuff_en = 1'b0;
    send_byte(8'hFC);
    data_bit(1'b1);
    send_byte(8'h55);
    stuff_en = 1'b1;
    check("stufferr_active_held", 32'(rx_active), 32'h1);
    send_eop();
    check("stufferr_count", 32'(rx_bytes.size() - b0), 32'd1);
    check("stufferr_byte0", 32'(byte_at(b0)), 32'hFC);
    check("stufferr_errors", 32'(err_cnt - e0), 32'd1);
    check("stufferr_active_after", 32'(rx_active), 32'h0);

    // Short SYNC: K K, then K J J
    mark();
    cur_k = 1'b0;
    nrzi_bit(1'b0);
    nrzi_bit(1'b1);
    cur_k = 1'b0;
    send_ls(2'b01, 24);
    nrzi_bit(1'b0);
    nrzi_bit(1'b0);
    nrzi_bit(1'b1);
    send_ls(2'b01, 24);
    check("short_rises", 32'(rise_cnt - a0), 32'd0);
    check("short_errors", 32'(err_cnt - e0), 32'd0);

    // Single-clock SE0 glitch in idle
    send_ls(2'b00, 1);
    {dm_rx, dp_rx} = 2'b01;
    @(posedge clk);
    #1;
    check("glitch_ls_se0", 32'(line_state), 32'(LS_SE0));
    @(posedge clk);
    #1;
    check("glitch_ls_j", 32'(line_state), 32'(LS_J));
    send_ls(2'b01, 24);
    check("glitch_rises", 32'(rise_cnt - a0), 32'd0);
    check("glitch_errors", 32'(err_cnt - e0), 32'd0);
    check("glitch_active", 32'(rx_active), 32'h0);

    // Misaligned EOP
    mark();
    send_sync();
    send_byte(8'h5A);
    data_bit(1'b1);
    data_bit(1'b0);
    data_bit(1'b1);
    send_eop();
    check("misalign_count", 32'(rx_bytes.size() - b0), 32'd1);
    check("misalign_byte0", 32'(byte_at(b0)), 32'h5A);
    check("misalign_errors", 32'(err_cnt - e0), 32'd1);
    check("misalign_active", 32'(rx_active), 32'h0);

    // Bit period alternating 3 / 5 clocks over 16 bytes
    mark();
    drift = 1'b1;
    drift_tgl = 1'b0;
    send_sync();
    for (int i = 0; i < 16; i++) send_byte(drift_bytes[i]);
    send_eop();
    drift = 1'b0;
    check("drift_count", 32'(rx_bytes.size() - b0), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("drift_byte%0d", i), 32'(byte_at(b0 + i)), 32'(drift_bytes[i]));
    check("drift_errors", 32'(err_cnt - e0), 32'd0);

    // Suspend mid-packet
    mark();
    send_sync();
    send_byte(8'h69);
    data_bit(1'b1);
    data_bit(1'b0);
    data_bit(1'b0);
    check("susp_active_before", 32'(rx_active), 32'h1);
    suspend_m = 1'b0;
    @(posedge clk);
    #1;
    check("susp_active_next", 32'(rx_active), 32'h0);
    send_ls(2'b10, 3);
    check("susp_ls_k", 32'(line_state), 32'(LS_K));
    send_ls(2'b01, 3);
    check("susp_ls_j", 32'(line_state), 32'(LS_J));
    send_ls(2'b01, 8);
    suspend_m = 1'b1;
    cur_k = 1'b0;
    send_ls(2'b01, 24);
    check("susp_count", 32'(rx_bytes.size() - b0), 32'd1);
    check("susp_byte0", 32'(byte_at(b0)), 32'h69);
    check("susp_errors", 32'(err_cnt - e0), 32'd0);
    check("susp_active_after", 32'(rx_active), 32'h0);

    // Reset mid-byte, then a clean packet
    send_sync();
    data_bit(1'b1);
    data_bit(1'b1);
    data_bit(1'b0);
    data_bit(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_line_state", 32'(line_state), 32'(LS_SE0));
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_rx_valid", 32'(rx_valid), 32'h0);
    check("midrst_rx_active", 32'(rx_active), 32'h0);
    check("midrst_rx_error", 32'(rx_error), 32'h0);
    rst = 1'b0;
    cur_k = 1'b0;
    send_ls(2'b01, 40);
    mark();
    send_sync();
    send_byte(8'h3C);
    send_byte(8'h96);
    send_eop();
    check("postrst_count", 32'(rx_bytes.size() - b0), 32'd2);
    check("postrst_byte0", 32'(byte_at(b0)), 32'h3C);
    check("postrst_byte1", 32'(byte_at(b0 + 1)), 32'h96);
    check("postrst_errors", 32'(err_cnt - e0), 32'd0);

    // Receiver disabled by op_mode
    mark();
    op_mode = OP_DISABLE_BS;
    send_sync();
    send_byte(8'h11);
    send_eop();
    op_mode = OP_NORMAL;
    check("opmode_count", 32'(rx_bytes.size() - b0), 32'd0);
    check("opmode_rises", 32'(rise_cnt - a0), 32'd0);

    check("valid_without_active", 32'(viol_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
